// File: rtl/regfile_param_if.sv
// regfile_param_if -- bus bundle for the parametrised register file.
//   master : drives the write port, read strobes/addresses and clear request
//   slave  : the register file; returns read data, busy and clearDone
// Ports carried:
//   write/writeReg/writeData/writeMask  byte-masked write port
//   readEn/readReg1/readReg2            shared read strobe, two read addresses
//   readData1/readData2                 registered read data
//   clearReq/busy/clearDone             bulk-clear request and status
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                  write;
  logic [ADDR_W-1:0]     writeReg;
  logic [DATA_W-1:0]     writeData;
  logic [DATA_W/8-1:0]   writeMask;
  logic                  readEn;
  logic [ADDR_W-1:0]     readReg1;
  logic [ADDR_W-1:0]     readReg2;
  logic [DATA_W-1:0]     readData1;
  logic [DATA_W-1:0]     readData2;
  logic                  clearReq;
  logic                  busy;
  logic                  clearDone;

  modport master (
    output write, writeReg, writeData, writeMask,
    output readEn, readReg1, readReg2, clearReq,
    input  readData1, readData2, busy, clearDone
  );

  modport slave (
    input  write, writeReg, writeData, writeMask,
    input  readEn, readReg1, readReg2, clearReq,
    output readData1, readData2, busy, clearDone
  );
endinterface

// File: rtl/regfile_param.sv
// regfile_param -- parametrised clocked register file.
//   One byte-masked write port, two registered read ports (1-cycle latency)
//   with optional write-to-read bypass, optional hardwired-zero entry 0, and
//   a bulk-clear engine that zeroes one entry per cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears every entry and all outputs)
//   bus    regfile_param_if slave modport (write, read and clear signals)
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  regfile_param_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   cnt_reg;
  logic                busy_reg;
  logic                done_reg;

  logic [DATA_W-1:0]       byte_mask;
  logic [DATA_W-1:0]       wr_old;
  logic [DATA_W-1:0]       wr_merged;
  logic [DATA_W-1:0]       raw1;
  logic [DATA_W-1:0]       raw2;
  logic [DATA_W-1:0]       rd1_next;
  logic [DATA_W-1:0]       rd2_next;
  logic [DATA_W-1:0]       rd1_reg;
  logic [DATA_W-1:0]       rd2_reg;
  logic [DEPTH*DATA_W-1:0] mem_flat;
  logic                    wr_in_range;
  logic                    wr_commit;

  // Expand one enable bit per byte into a full-width bit mask.
  for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_mask
    assign byte_mask[gi*8 +: 8] = {8{bus.writeMask[gi]}};
  end

  assign wr_in_range = (32'(bus.writeReg) < 32'(DEPTH));
  // A write only lands when it is in range, not aimed at a hardwired zero,
  // and the clear sweep is not running. Bypass keys off this same signal,
  // so dropped writes are never forwarded.
  assign wr_commit = bus.write && !busy_reg && wr_in_range &&
                     !((ZERO_REG != 0) && (bus.writeReg == '0));

  // Entries are plain flops: the asynchronous reset has to clear them all.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [DATA_W-1:0] q;
    logic              clr_hit;
    logic              wr_hit;

    assign clr_hit = (state_reg == CLEAR) && (cnt_reg == ADDR_W'(gi));
    assign wr_hit  = wr_commit && (bus.writeReg == ADDR_W'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (clr_hit) begin
        q <= '0;
      end else if (wr_hit) begin
        q <= wr_merged;
      end
    end

    assign mem_flat[gi*DATA_W +: DATA_W] = q;
  end

  // Address decode for both read ports and the write port's old value.
  // Addresses at or beyond DEPTH match no entry and read as zero.
  always_comb begin
    raw1   = '0;
    raw2   = '0;
    wr_old = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.readReg1 == ADDR_W'(i)) raw1   = mem_flat[i*DATA_W +: DATA_W];
      if (bus.readReg2 == ADDR_W'(i)) raw2   = mem_flat[i*DATA_W +: DATA_W];
      if (bus.writeReg == ADDR_W'(i)) wr_old = mem_flat[i*DATA_W +: DATA_W];
    end
  end

  assign wr_merged = (wr_old & ~byte_mask) | (bus.writeData & byte_mask);

  always_comb begin
    rd1_next = raw1;
    if ((ZERO_REG != 0) && (bus.readReg1 == '0)) begin
      rd1_next = '0;
    end else if ((BYPASS != 0) && wr_commit && (bus.readReg1 == bus.writeReg)) begin
      rd1_next = wr_merged;
    end
  end

  always_comb begin
    rd2_next = raw2;
    if ((ZERO_REG != 0) && (bus.readReg2 == '0)) begin
      rd2_next = '0;
    end else if ((BYPASS != 0) && wr_commit && (bus.readReg2 == bus.writeReg)) begin
      rd2_next = wr_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_reg <= '0;
      rd2_reg <= '0;
    end else if (bus.readEn && !busy_reg) begin
      rd1_reg <= rd1_next;
      rd2_reg <= rd2_next;
    end
  end

  // Clear sweep. busy/clearDone are registered copies of the state being
  // entered, so busy is high exactly for the DEPTH cycles spent in CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.clearReq) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_reg == ADDR_W'(DEPTH - 1)) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.readData1 = rd1_reg;
  assign bus.readData2 = rd2_reg;
  assign bus.busy      = busy_reg;
  assign bus.clearDone = done_reg;

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param -- directed bench for regfile_param.
//   Three instances share one stimulus stream:
//     dut_a : defaults (DEPTH=32, ZERO_REG=1, BYPASS=1)
//     dut_b : BYPASS=0
//     dut_c : DEPTH=16
//   Expected values are hand-computed constants.
module tb_regfile_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        w;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        ren;
  logic [4:0]  r1;
  logic [4:0]  r2;
  logic        creq;

  regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
  regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
  regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus_c ();

  assign bus_a.write = w;    assign bus_b.write = w;    assign bus_c.write = w;
  assign bus_a.writeReg = wreg;  assign bus_b.writeReg = wreg;  assign bus_c.writeReg = wreg;
  assign bus_a.writeData = wdata; assign bus_b.writeData = wdata; assign bus_c.writeData = wdata;
  assign bus_a.writeMask = wmask; assign bus_b.writeMask = wmask; assign bus_c.writeMask = wmask;
  assign bus_a.readEn = ren;  assign bus_b.readEn = ren;  assign bus_c.readEn = ren;
  assign bus_a.readReg1 = r1; assign bus_b.readReg1 = r1; assign bus_c.readReg1 = r1;
  assign bus_a.readReg2 = r2; assign bus_b.readReg2 = r2; assign bus_c.readReg2 = r2;
  assign bus_a.clearReq = creq; assign bus_b.clearReq = creq; assign bus_c.clearReq = creq;

  regfile_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  regfile_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  regfile_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .ZERO_REG(1), .BYPASS(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("check %s: got %h ok", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic dw, input logic [4:0] dwreg, input logic [31:0] dwdata,
                       input logic [3:0] dwmask, input logic dren, input logic [4:0] dr1,
                       input logic [4:0] dr2, input logic dcreq);
    w = dw; wreg = dwreg; wdata = dwdata; wmask = dwmask;
    ren = dren; r1 = dr1; r2 = dr2; creq = dcreq;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  // Pulse clearReq (with a write and read on the same edge), then keep
  // hammering writes/reads while busy. Returns busy-high cycles and the
  // number of clearDone pulses seen up to two cycles after busy drops.
  task automatic run_clear(output int busy_cycles, output int done_pulses);
    busy_cycles = 0;
    done_pulses = 0;
    drive(1'b1, 5'd3, 32'h33333333, 4'hF, 1'b1, 5'd31, 5'd9, 1'b1);
    step();
    drive(1'b1, 5'd9, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd0, 5'd1, 1'b0);
    while (bus_a.busy && busy_cycles < 40) begin
      busy_cycles++;
      if (bus_a.clearDone) done_pulses++;
      step();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      if (bus_a.clearDone) done_pulses++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int dc;
    logic [31:0] acc;

    idle();
    rst_n = 1'b0;
    step();
    step();
    check("reset_rd1", bus_a.readData1, 32'h0);
    check("reset_rd2", bus_a.readData2, 32'h0);
    check("reset_busy", 32'(bus_a.busy), 32'h0);
    check("reset_done", 32'(bus_a.clearDone), 32'h0);
    rst_n = 1'b1;
    step();

    // Read after reset
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3, 5'd31, 1'b0);
    step();
    check("post_reset_rd1", bus_a.readData1, 32'h0);
    check("post_reset_rd2", bus_a.readData2, 32'h0);
    check("post_reset_busy", 32'(bus_a.busy), 32'h0);
    check("post_reset_done", 32'(bus_a.clearDone), 32'h0);

    // Byte-masked write
    drive(1'b1, 5'd5, 32'hAABBCCDD, 4'hF, 1'b0, 5'd0, 5'd0, 1'b0); step();
    drive(1'b1, 5'd5, 32'h11223344, 4'h5, 1'b0, 5'd0, 5'd0, 1'b0); step();
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd5, 5'd5, 1'b0); step();
    check("mask_rd1", bus_a.readData1, 32'hAA22CC44);
    check("mask_rd2", bus_a.readData2, 32'hAA22CC44);
    check("mask_nobyp_rd1", bus_b.readData1, 32'hAA22CC44);

    // Zero register: write and read reg 0 on the same edge, then again
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd0, 5'd5, 1'b0); step();
    check("zero_same_edge", bus_a.readData1, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd0, 5'd0, 1'b0); step();
    check("zero_rd1", bus_a.readData1, 32'h0);

    // Out of range on DEPTH=16: reg 20 dropped, reg 4 (alias) untouched
    drive(1'b1, 5'd4, 32'h44444444, 4'hF, 1'b0, 5'd0, 5'd0, 1'b0); step();
    drive(1'b1, 5'd20, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 5'd0, 1'b0); step();
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd20, 5'd4, 1'b0); step();
    check("oor_d16_rd20", bus_c.readData1, 32'h0);
    check("oor_d16_rd4", bus_c.readData2, 32'h44444444);
    check("inrange_d32_rd20", bus_a.readData1, 32'hDEADBEEF);

    // Bypass on reg 7
    drive(1'b1, 5'd7, 32'h00000001, 4'hF, 1'b0, 5'd0, 5'd0, 1'b0); step();
    drive(1'b1, 5'd7, 32'h12345678, 4'hF, 1'b1, 5'd7, 5'd7, 1'b0); step();
    check("byp1_rd1", bus_a.readData1, 32'h12345678);
    check("byp1_rd2", bus_a.readData2, 32'h12345678);
    check("byp0_rd1", bus_b.readData1, 32'h00000001);
    check("byp0_rd2", bus_b.readData2, 32'h00000001);
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd7, 5'd7, 1'b0); step();
    check("byp1_next", bus_a.readData1, 32'h12345678);
    check("byp0_next", bus_b.readData1, 32'h12345678);
    // Partial-mask bypass
    drive(1'b1, 5'd7, 32'hAABBCCDD, 4'h3, 1'b1, 5'd7, 5'd5, 1'b0); step();
    check("byp1_partial", bus_a.readData1, 32'h1234CCDD);
    check("byp0_partial", bus_b.readData1, 32'h12345678);

    // Fill every entry, then set known read outputs
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i + 1) * 32'h01010101, 4'hF, 1'b0, 5'd0, 5'd0, 1'b0);
      step();
    end
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd9, 5'd31, 1'b0); step();
    check("fill_rd9", bus_a.readData1, 32'h0A0A0A0A);
    check("fill_rd31", bus_a.readData2, 32'h20202020);

    // Bulk clear; the read at the clearReq edge swaps the ports
    run_clear(bc, dc);
    check("clear_busy_cycles", 32'(bc), 32'd32);
    check("clear_done_pulses", 32'(dc), 32'd1);
    check("clear_hold_rd1", bus_a.readData1, 32'h20202020);
    check("clear_hold_rd2", bus_a.readData2, 32'h0A0A0A0A);
    acc = 32'h0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'(i), 5'(i + 16), 1'b0);
      step();
      acc = acc | bus_a.readData1 | bus_a.readData2;
    end
    idle();
    check("clear_all_zero", acc, 32'h0);

    // Reset in the middle of a sweep
    drive(1'b1, 5'd6, 32'h66666666, 4'hF, 1'b0, 5'd0, 5'd0, 1'b0); step();
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd6, 5'd6, 1'b0); step();
    check("pre_midrst_rd6", bus_a.readData1, 32'h66666666);
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd0, 1'b1); step();
    idle();
    for (int k = 0; k < 10; k++) step();
    check("midrst_busy_before", 32'(bus_a.busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus_a.busy), 32'h0);
    check("midrst_rd1", bus_a.readData1, 32'h0);
    check("midrst_done", 32'(bus_a.clearDone), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    dc = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus_a.clearDone || bus_a.busy) dc++;
      step();
    end
    check("midrst_no_activity", 32'(dc), 32'd0);
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd6, 5'd31, 1'b0); step();
    idle();
    check("midrst_rd6_zero", bus_a.readData1, 32'h0);
    run_clear(bc, dc);
    check("restart_busy_cycles", 32'(bc), 32'd32);
    check("restart_done_pulses", 32'(dc), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
